// File: rtl/enc_pipe.sv
// Two-stage elastic SECDED encoder for (8,4), (16,11) and (32,26) extended-Hamming codes.
// Define ENC_ERR_INJECT_EN to add the inj_mask port, which XORs an error pattern onto the codeword.
module enc_pipe #(
    parameter int MAX_CODEWORD_WIDTH = 32,
    parameter int MAX_INFO_WIDTH     = 26
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [MAX_INFO_WIDTH-1:0]     data_in,
    input  logic [1:0]                    mod,
`ifdef ENC_ERR_INJECT_EN
    input  logic [MAX_CODEWORD_WIDTH-1:0] inj_mask,
`endif
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [MAX_CODEWORD_WIDTH-1:0] data_out,
    output logic [1:0]                    mod_out,
    output logic                          illegal_mod
);

    localparam logic [1:0] MOD_8_4   = 2'b00;
    localparam logic [1:0] MOD_16_11 = 2'b01;
    localparam logic [1:0] MOD_32_26 = 2'b10;
    localparam logic [1:0] MOD_ILL   = 2'b11;

    function automatic logic [25:0] info_window(input logic [1:0] m);
        case (m)
            MOD_8_4:   return 26'h000000F;
            MOD_16_11: return 26'h00007FF;
            MOD_32_26: return 26'h3FFFFFF;
            default:   return 26'h0000000;
        endcase
    endfunction

    function automatic logic [31:0] cw_window(input logic [1:0] m);
        case (m)
            MOD_8_4:   return 32'h000000FF;
            MOD_16_11: return 32'h0000FFFF;
            MOD_32_26: return 32'hFFFFFFFF;
            default:   return 32'h00000000;
        endcase
    endfunction

    // The info word is already masked, so the parity walk can run over every position
    // regardless of mode: unused info bits are zero and contribute nothing.
    function automatic logic [31:0] encode(input logic [25:0] info, input logic [1:0] m);
        logic [4:0] par;
        logic [4:0] idx;
        logic       ovr;
        logic [31:0] cw;
        par = '0;
        idx = '0;
        for (int pos = 1; pos < 32; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                if (info[idx]) par = par ^ 5'(pos);
                idx = idx + 5'd1;
            end
        end
        ovr = (^info) ^ (^par);
        case (m)
            MOD_8_4:   cw = {24'd0, info[3:0], ovr, par[2:0]};
            MOD_16_11: cw = {16'd0, info[10:0], ovr, par[3:0]};
            MOD_32_26: cw = {info, ovr, par};
            default:   cw = 32'd0;
        endcase
        return cw;
    endfunction

    logic        s1_valid;
    logic [25:0] s1_info;
    logic [1:0]  s1_mod;
`ifdef ENC_ERR_INJECT_EN
    logic [31:0] s1_inj;
`endif

    logic        s2_valid;
    logic [31:0] s2_data;
    logic [1:0]  s2_mod;
    logic        s2_ill;

    logic        s2_ready;
    logic        s1_move;
    logic        in_fire;
    logic [31:0] s1_code;

    assign s2_ready = !s2_valid || out_ready;
    assign s1_move  = s1_valid && s2_ready;
    assign in_ready = !s1_valid || s1_move;
    assign in_fire  = in_valid && in_ready;

`ifdef ENC_ERR_INJECT_EN
    assign s1_code = encode(s1_info, s1_mod) ^ (s1_inj & cw_window(s1_mod));
`else
    assign s1_code = encode(s1_info, s1_mod);
`endif

    // NOTE: state registers use non-blocking assignments so every stage samples the
    // pre-edge value of its neighbour; blocking here would let a word skip a stage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_info  <= '0;
            s1_mod   <= '0;
`ifdef ENC_ERR_INJECT_EN
            s1_inj   <= '0;
`endif
        end else if (in_fire) begin
            s1_valid <= 1'b1;
            s1_info  <= data_in[25:0] & info_window(mod);
            s1_mod   <= mod;
`ifdef ENC_ERR_INJECT_EN
            s1_inj   <= inj_mask[31:0];
`endif
        end else if (s1_move) begin
            s1_valid <= 1'b0;
        end
    end

    // NOTE: the output payload is reset and cleared on drain, not just the valid bit,
    // because data_out must read 0 whenever out_valid is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_mod   <= '0;
            s2_ill   <= 1'b0;
        end else if (s1_move) begin
            s2_valid <= 1'b1;
            s2_data  <= s1_code;
            s2_mod   <= s1_mod;
            s2_ill   <= (s1_mod == MOD_ILL);
        end else if (s2_valid && out_ready) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_mod   <= '0;
            s2_ill   <= 1'b0;
        end
    end

    assign out_valid   = s2_valid;
    assign data_out    = MAX_CODEWORD_WIDTH'(s2_data);
    assign mod_out     = s2_mod;
    assign illegal_mod = s2_ill;

endmodule

// File: tb/tb_enc_pipe.sv
// Directed bench for enc_pipe: code values, masking, illegal mode, backpressure, async reset.
// Exercises the inj_mask port as well when ENC_ERR_INJECT_EN is defined.
module tb_enc_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [25:0] data_in;
    logic [1:0]  mod;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] data_out;
    logic [1:0]  mod_out;
    logic        illegal_mod;
`ifdef ENC_ERR_INJECT_EN
    logic [31:0] inj_mask;
`endif

    int vectors = 0;
    int fails   = 0;

    enc_pipe dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .data_in    (data_in),
        .mod        (mod),
`ifdef ENC_ERR_INJECT_EN
        .inj_mask   (inj_mask),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .data_out   (data_out),
        .mod_out    (mod_out),
        .illegal_mod(illegal_mod)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] m, input logic [25:0] d, input logic [31:0] inj);
        int n;
        in_valid = 1'b1;
        mod      = m;
        data_in  = d;
`ifdef ENC_ERR_INJECT_EN
        inj_mask = inj;
`else
        if (inj != 32'd0) $display("note: inj ignored without injection build");
`endif
        #1;
        n = 0;
        while (!in_ready && n < 20) begin
            cyc();
            n++;
        end
        if (n >= 20) check("push_timeout", 32'(in_ready), 32'd1);
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic pull(input string tag, input logic [31:0] exp_d, input logic [1:0] exp_m,
                        input logic exp_i);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            cyc();
            n++;
        end
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_data"}, data_out, exp_d);
        check({tag, "_mod"}, 32'(mod_out), 32'(exp_m));
        check({tag, "_ill"}, 32'(illegal_mod), 32'(exp_i));
        out_ready = 1'b1;
        cyc();
    endtask

    logic [31:0] bp_exp [4];

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        data_in   = '0;
        mod       = 2'b00;
        out_ready = 1'b1;
`ifdef ENC_ERR_INJECT_EN
        inj_mask  = '0;
`endif
        repeat (3) cyc();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_data_out", data_out, 32'd0);
        check("rst_mod_out", 32'(mod_out), 32'd0);
        check("rst_illegal", 32'(illegal_mod), 32'd0);
        rst = 1'b1;
        cyc();
        check("rel_in_ready", 32'(in_ready), 32'd1);

        push(2'b00, 26'h000000B, 32'd0);
        pull("m00_b", 32'h000000B1, 2'b00, 1'b0);
        push(2'b01, 26'h00007FF, 32'd0);
        pull("m01_ones", 32'h0000FFFF, 2'b01, 1'b0);
        push(2'b10, 26'h3FFFFFF, 32'd0);
        pull("m10_ones", 32'hFFFFFFFF, 2'b10, 1'b0);
        push(2'b01, 26'h0000001, 32'd0);
        pull("m01_one", 32'h00000033, 2'b01, 1'b0);
        push(2'b10, 26'h0000001, 32'd0);
        pull("m10_one", 32'h00000063, 2'b10, 1'b0);
        push(2'b00, 26'h3FFFFF0, 32'd0);
        pull("m00_masked", 32'h00000000, 2'b00, 1'b0);
        push(2'b01, 26'h3FFF801, 32'd0);
        pull("m01_masked", 32'h00000033, 2'b01, 1'b0);

        push(2'b11, 26'h0000123, 32'd0);
        pull("m11", 32'h00000000, 2'b11, 1'b1);
        push(2'b00, 26'h000000B, 32'd0);
        pull("after_m11", 32'h000000B1, 2'b00, 1'b0);

        // Backpressure: two words fill the pipe, the third waits until the sink opens.
        bp_exp[0] = 32'h0000002D;
        bp_exp[1] = 32'h00000036;
        bp_exp[2] = 32'h0000004E;
        bp_exp[3] = 32'h00000055;
        out_ready = 1'b0;
        push(2'b00, 26'h1, 32'd0);
        push(2'b00, 26'h2, 32'd0);
        in_valid = 1'b1;
        mod      = 2'b00;
        data_in  = 26'h3;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("bp_in_ready_low", 32'(in_ready), 32'd0);
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_data", data_out, 32'h0000001B);
            cyc();
        end
        out_ready = 1'b1;
        #1;
        check("bp_in_ready_open", 32'(in_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("bp_stream_valid", 32'(out_valid), 32'd1);
            check("bp_stream_data", data_out, bp_exp[i]);
            if (i < 3) check("bp_stream_in_ready", 32'(in_ready), 32'd1);
            if (i < 2) data_in = 26'(4 + i);
            else in_valid = 1'b0;
        end
        cyc();
        check("bp_drained_valid", 32'(out_valid), 32'd0);
        check("bp_drained_data", data_out, 32'd0);

        // Async reset with two words in flight.
        out_ready = 1'b0;
        push(2'b00, 26'h1, 32'd0);
        push(2'b00, 26'h2, 32'd0);
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_data", data_out, 32'd0);
        cyc();
        rst = 1'b1;
        out_ready = 1'b1;
        cyc();
        check("post_rst_no_stale", 32'(out_valid), 32'd0);
        push(2'b00, 26'h3, 32'd0);
        pull("post_rst_first", 32'h00000036, 2'b00, 1'b0);

`ifdef ENC_ERR_INJECT_EN
        push(2'b00, 26'h000000B, 32'h00000010);
        pull("inj_bit4", 32'h000000A1, 2'b00, 1'b0);
        push(2'b00, 26'h000000B, 32'h00000100);
        pull("inj_above_n", 32'h000000B1, 2'b00, 1'b0);
        inj_mask = '0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/enc_pipe.md
Name: enc_pipe

Overview:
- Pipelined systematic extended-Hamming (SECDED) encoder; the transmit-side counterpart of the team's DEC block.
- Accepts info words in three modes: (8,4), (16,11), (32,26).
- Emits codewords whose info field sits in the upper bits and parity in the low bits, the layout DEC strips.
- Two-stage elastic pipeline with valid/ready on both sides, so it can sit between a data source and the channel/DEC under backpressure.

Parameters:
- MAX_CODEWORD_WIDTH, 32, output codeword width; codewords are zero-extended to this width.
- MAX_INFO_WIDTH, 26, input info width; unused upper bits are ignored per mode.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset; asynchronous assert, active-low (0 = reset).
- in_valid  input  1  data_in/mod valid.
- in_ready  output  1  block can accept this cycle.
- data_in  input  MAX_INFO_WIDTH  info word, LSB = info[0].
- mod  input  2  00=(8,4), 01=(16,11), 10=(32,26), 11=illegal.
- out_valid  output  1  data_out valid.
- out_ready  input  1  sink accepts this cycle.
- data_out  output  MAX_CODEWORD_WIDTH  codeword.
- mod_out  output  2  mode accompanying data_out.
- illegal_mod  output  1  data_out produced from mod=11.

Behaviour:
- Reset (rst=0, async): both stage valids cleared; out_valid=0, data_out=0, mod_out=0, illegal_mod=0. in_ready=1 from the first cycle after release.
- An in-flight word lost to reset mid-operation is dropped; no output is produced for it.
- Handshakes:
  - Input transfer on in_valid&in_ready; output transfer on out_valid&out_ready.
  - Once out_valid=1, data_out, mod_out and illegal_mod hold stable until the transfer completes.
- Pipeline:
  - S1 registers the masked info word and mod.
  - S2 registers the computed codeword.
  - Latency: input transfer at edge N gives out_valid at edge N+1 output, visible the cycle after. Equivalently, 2 registered stages, 2 cycles from acceptance to data_out when there is no stall.
  - A stage loads when it is empty or its content moves on in the same cycle.
  - in_ready = !s1_valid | (s1 moves to S2 this cycle). in_ready depends combinationally on out_ready only through this chain.
  - Full throughput is 1 word/cycle while out_ready=1.
  - With out_ready=0 both stages fill; in_ready drops after 2 words are held.
  - Simultaneous in and out transfer in the same cycle is legal and loses no word.
- Code definition for K info bits and P parity bits (K,P = 4,4 / 11,5 / 26,6):
  - Hamming positions 1..K+P-1.
  - info[i] maps to the i-th non-power-of-two position in ascending order (info[0] maps to 3).
  - p_j (j=0..P-2) = XOR of the info bits whose position has bit j set.
  - codeword[j] = p_j for j<P-1.
  - codeword[P-1] = overall parity, giving even parity over all K+P bits.
  - codeword[K+P-1:P] = data_in[K-1:0].
  - Bits ≥K+P are 0.
  - data_in bits ≥K are ignored (masked at S1).
- mod=11:
  - Word is accepted normally and data_out=0.
  - illegal_mod=1, mod_out=11.
  - Pipeline is not stalled.
- No X propagation: data_out is 0 whenever out_valid=0 after reset.

Optional Feature:
- Macro ENC_ERR_INJECT_EN.
- When defined:
  - Extra input inj_mask[MAX_CODEWORD_WIDTH-1:0] is sampled with the input transfer and carried through S1.
  - It is XORed onto the S2 codeword. Bits ≥K+P of the mask are ignored.
  - It is used to drive 1/2-bit error cases into DEC.
- When undefined: the port is absent and the codeword is never altered.

Test Plan:
- mod=00, data_in=0xB, out_ready=1 → 2 cycles later data_out=0x000000B1, mod_out=00, illegal_mod=0.
- mod=01, data_in=0x7FF → data_out=0x0000FFFF; mod=10, data_in=0x3FFFFFF → data_out=0xFFFFFFFF.
- mod=00, data_in=0x3FFFFF0 (upper bits set) → data_out=0x00000000 (masked).
- Backpressure:
  - Stimulus: stream 5 words back-to-back with out_ready=0 for 4 cycles, then 1.
  - Response: in_ready=0 after 2 accepted; all 5 outputs in order, none dropped or duplicated; data_out stable while stalled.
- mod=11, data_in=0x123 → data_out=0, illegal_mod=1; next word (mod=00, 0xB) → 0xB1 with illegal_mod=0.
- Reset and injection:
  - Assert rst=0 mid-stream with 2 words in flight → out_valid=0 immediately (async); after release, first output is the next word accepted.
  - With ENC_ERR_INJECT_EN, mod=00, 0xB, inj_mask=0x10 → data_out=0xA1.
